seg_display_arbiter: RTL and testbench

- Decides which 16-bit, 4-nibble value the SevenSegment scanner displays.
- Arbitrates between three sources:
  - Base source: always valid; game timer.
  - Alternate source: pulsed and time-limited; mine/flag count on request.
  - Message source: level, highest priority; WIN/LOSE/ERR glyphs, with optional blinking.
- Sits between the game FSM and the SevenSegment `nums` input.
- Owns the minimum hold time for each screen and the blink cadence.

---
 rtl/seg_ctrl_pkg.sv | 35 +++
 rtl/seg_hold_timer.sv | 44 ++++
 rtl/seg_display_arbiter.sv | 139 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_ctrl_pkg.sv
// Shared types, glyph codes and nibble helpers for the seven-segment display path.
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        BASE = 2'd0,
        ALT  = 2'd1,
        MSG  = 2'd2
    } state_e;

    localparam logic [1:0] SRC_BASE = 2'd0;
    localparam logic [1:0] SRC_ALT  = 2'd1;
    localparam logic [1:0] SRC_MSG  = 2'd2;

    localparam logic [3:0] GLY_DASH  = 4'd10;
    localparam logic [3:0] GLY_BLANK = 4'd11;
    localparam logic [3:0] GLY_UNDEF = 4'd12;
    localparam logic [3:0] GLY_E     = 4'd13;
    localparam logic [3:0] GLY_A     = 4'd14;
    localparam logic [3:0] GLY_F     = 4'd15;

    localparam logic [15:0] BLANK_ALL = 16'hBBBB;

    // Code 12 has no glyph in the decoder, so it is shown as blank.
    function automatic logic [15:0] sanitize_nums(input logic [15:0] raw);
        logic [15:0] res;
        res = raw;
        for (int i = 0; i < 4; i++) begin
            if (raw[4*i +: 4] == GLY_UNDEF) begin
                res[4*i +: 4] = GLY_BLANK;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_hold_timer.sv
// Loadable down-counter that saturates at zero, or reloads itself when AUTO_RELOAD is set.
module seg_hold_timer #(
    parameter int W           = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (count_q != '0) begin
                count_d = count_q - W'(1);
            end else if (AUTO_RELOAD) begin
                count_d = load_val_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == '0);

endmodule

// File: rtl/seg_display_arbiter.sv
// Chooses among base, alternate and message screens for the SevenSegment scanner,
// enforcing a minimum on-screen hold and the message blink cadence.
module seg_display_arbiter
    import seg_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES  = 100000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] base_nums,
    input  logic        alt_req,
    input  logic [15:0] alt_nums,
    input  logic        msg_req,
    input  logic [15:0] msg_nums,
    input  logic        msg_blink,
    output logic [15:0] nums,
    output logic [1:0]  src,
    output logic        hold_active
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLINK_LOAD = BLK_W'(BLINK_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] nums_q, nums_d, raw_nums;
    logic [1:0]  src_q, src_d;
    logic        hold_active_q, hold_active_d;
    logic        phase_q, phase_d;

    logic             hold_load, hold_done;
    logic [CNT_W-1:0] hold_cnt;
    logic             blink_load, blink_en, blink_done;
    logic [BLK_W-1:0] blink_cnt_unused;

    seg_hold_timer #(.W(CNT_W), .AUTO_RELOAD(1'b0)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .en_i       (1'b1),
        .count_o    (hold_cnt),
        .done_o     (hold_done)
    );

    seg_hold_timer #(.W(BLK_W), .AUTO_RELOAD(1'b1)) u_blink (
        .clk        (clk),
        .rst        (rst),
        .load_i     (blink_load),
        .load_val_i (BLINK_LOAD),
        .en_i       (blink_en),
        .count_o    (blink_cnt_unused),
        .done_o     (blink_done)
    );

    // A message always wins; an alt request arriving during MSG is simply dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BASE: begin
                if (msg_req)      state_d = MSG;
                else if (alt_req) state_d = ALT;
            end
            ALT: begin
                if (msg_req)        state_d = MSG;
                else if (alt_req)   state_d = ALT;
                else if (hold_done) state_d = BASE;
            end
            MSG: begin
                if (!msg_req && hold_done) state_d = BASE;
            end
            default: state_d = BASE;
        endcase
    end

    always_comb begin
        hold_load  = ((state_d != state_q) && (state_d != BASE))
                   || ((state_q == ALT) && (state_d == ALT) && alt_req);
        blink_load = (state_d == MSG) && (state_q != MSG);
        blink_en   = (state_q == MSG);

        phase_d = phase_q;
        if (blink_load) begin
            phase_d = 1'b1;
        end else if (blink_en && blink_done) begin
            phase_d = ~phase_q;
        end

        hold_active_d = hold_load ? (HOLD_LOAD != '0) : (hold_cnt > CNT_W'(1));
    end

    // Mux on the next state so src and nums always describe the same screen.
    always_comb begin
        raw_nums = base_nums;
        src_d    = SRC_BASE;
        unique case (state_d)
            BASE: begin
                raw_nums = base_nums;
                src_d    = SRC_BASE;
            end
            ALT: begin
                raw_nums = alt_nums;
                src_d    = SRC_ALT;
            end
            MSG: begin
                raw_nums = (phase_d || !msg_blink) ? msg_nums : BLANK_ALL;
                src_d    = SRC_MSG;
            end
            default: begin
                raw_nums = BLANK_ALL;
                src_d    = SRC_BASE;
            end
        endcase
        nums_d = sanitize_nums(raw_nums);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BASE;
            nums_q        <= BLANK_ALL;
            src_q         <= SRC_BASE;
            hold_active_q <= 1'b0;
            phase_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            nums_q        <= nums_d;
            src_q         <= src_d;
            hold_active_q <= hold_active_d;
            phase_q       <= phase_d;
        end
    end

    assign nums        = nums_q;
    assign src         = src_q;
    assign hold_active = hold_active_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based screen model.
module tb_seg_display_arbiter;

    localparam int HOLD  = 8;
    localparam int BLINK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] base_nums, alt_nums, msg_nums;
    logic        alt_req, msg_req, msg_blink;
    logic [15:0] nums;
    logic [1:0]  src;
    logic        hold_active;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    seg_display_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
        .clk         (clk),
        .rst         (rst),
        .base_nums   (base_nums),
        .alt_req     (alt_req),
        .alt_nums    (alt_nums),
        .msg_req     (msg_req),
        .msg_nums    (msg_nums),
        .msg_blink   (msg_blink),
        .nums        (nums),
        .src         (src),
        .hold_active (hold_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] model_clean(input logic [15:0] v);
        logic [15:0] r;
        int n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            n = int'((v >> (4 * i)) & 16'hF);
            if (n == 12) n = 11;
            r = r | (16'(n) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd_nums();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r = r << 4;
            r[3:0] = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
        end
        return r;
    endfunction

    // Model: screen mode 0/1/2, plus cycle timestamps of the last hold (re)start and MSG entry.
    int          m_mode = 0;
    int          m_cyc = 0;
    int          m_hold_start = 0;
    int          m_msg_start = 0;
    int          m_next;
    bit          m_hold_over;
    logic [15:0] exp_nums;
    logic [1:0]  exp_src;
    logic        exp_ha;
    logic [15:0] m_raw;

    always @(posedge clk) begin
        if (rst) begin
            m_mode   = 0;
            m_cyc    = 0;
            exp_nums = 16'hBBBB;
            exp_src  = 2'd0;
            exp_ha   = 1'b0;
        end else begin
            m_hold_over = (m_mode == 0) || ((m_cyc - m_hold_start) >= HOLD - 1);
            if (m_mode == 0)      m_next = msg_req ? 2 : (alt_req ? 1 : 0);
            else if (m_mode == 1) m_next = msg_req ? 2 : (alt_req ? 1 : (m_hold_over ? 0 : 1));
            else                  m_next = (!msg_req && m_hold_over) ? 0 : 2;
            m_cyc++;
            if (m_next != 0 && (m_next != m_mode || (m_mode == 1 && alt_req))) m_hold_start = m_cyc;
            if (m_next == 2 && m_mode != 2) m_msg_start = m_cyc;
            m_mode = m_next;
            if (m_mode == 0)      m_raw = base_nums;
            else if (m_mode == 1) m_raw = alt_nums;
            else if (!msg_blink || (((m_cyc - m_msg_start) / BLINK) % 2) == 0) m_raw = msg_nums;
            else                  m_raw = 16'hBBBB;
            exp_nums = model_clean(m_raw);
            exp_src  = 2'(m_mode);
            exp_ha   = (m_mode != 0) && ((m_cyc - m_hold_start) < HOLD - 1);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("nums", nums, exp_nums);
            check("src", {14'd0, src}, {14'd0, exp_src});
            check("hold_active", {15'd0, hold_active}, {15'd0, exp_ha});
        end
    end

    // Length of the most recently completed run of a given src value.
    int         ep_len = 0;
    int         ep_run = 0;
    logic [1:0] ep_src = 2'd0;
    logic [1:0] ep_prev = 2'd0;

    always @(negedge clk) begin
        if (src !== ep_prev) begin
            ep_len  = ep_run;
            ep_src  = ep_prev;
            ep_run  = 1;
            ep_prev = src;
        end else begin
            ep_run++;
        end
    end

    logic [15:0] pat [6];

    initial begin
        rst       = 1'b1;
        base_nums = 16'h1234;
        alt_nums  = 16'h0000;
        msg_nums  = 16'h0000;
        alt_req   = 1'b0;
        msg_req   = 1'b0;
        msg_blink = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_nums", nums, 16'hBBBB);
        cmp_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("base_after_reset", nums, 16'h1234);
        check("base_src", {14'd0, src}, 16'd0);

        // Single alt pulse: exactly HOLD cycles.
        alt_req  = 1'b1;
        alt_nums = 16'h0042;
        @(negedge clk);
        alt_req = 1'b0;
        check("alt_nums", nums, 16'h0042);
        check("alt_src", {14'd0, src}, 16'd1);
        repeat (12) @(negedge clk);
        @(posedge clk);
        check("alt_len", 16'(ep_len), 16'd8);
        check("alt_len_src", {14'd0, ep_src}, 16'd1);

        // Second alt pulse five cycles later extends the screen to 5 + 8.
        @(negedge clk);
        alt_req = 1'b1;
        @(negedge clk);
        alt_req = 1'b0;
        repeat (4) @(negedge clk);
        alt_req = 1'b1;
        @(negedge clk);
        alt_req = 1'b0;
        repeat (15) @(negedge clk);
        @(posedge clk);
        check("alt_ext_len", 16'(ep_len), 16'd13);

        // Short message request: still held for the minimum time.
        @(negedge clk);
        msg_req  = 1'b1;
        msg_nums = 16'hDEAF;
        @(negedge clk);
        check("msg_nums", nums, 16'hDEAF);
        check("msg_src", {14'd0, src}, 16'd2);
        @(negedge clk);
        msg_req = 1'b0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        check("msg_short_len", 16'(ep_len), 16'd8);

        // Long blinking message.
        @(negedge clk);
        msg_req   = 1'b1;
        msg_blink = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat[k] = nums;
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("blink_%0d", k), pat[k], (k < 3) ? 16'hDEAF : 16'hBBBB);
        end
        repeat (14) @(negedge clk);
        msg_req = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        check("msg_long_len", 16'(ep_len), 16'd20);
        msg_blink = 1'b0;

        // Simultaneous alt and msg requests.
        @(negedge clk);
        alt_req = 1'b1;
        msg_req = 1'b1;
        @(negedge clk);
        alt_req = 1'b0;
        msg_req = 1'b0;
        check("simul_src", {14'd0, src}, 16'd2);
        repeat (10) @(negedge clk);
        check("simul_after", {14'd0, src}, 16'd0);

        // Message preempts alt; alt is not resumed.
        alt_req = 1'b1;
        @(negedge clk);
        alt_req = 1'b0;
        repeat (2) @(negedge clk);
        msg_req = 1'b1;
        @(negedge clk);
        msg_req = 1'b0;
        check("preempt_src", {14'd0, src}, 16'd2);
        repeat (10) @(negedge clk);
        check("preempt_after", {14'd0, src}, 16'd0);
        check("preempt_nums", nums, 16'h1234);

        // Undefined glyph code is blanked.
        base_nums = 16'hC9C0;
        @(negedge clk);
        check("sanitize", nums, 16'hB9B0);

        // Reset in the middle of a message.
        msg_req = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_nums", nums, 16'hBBBB);
        check("midrst_src", {14'd0, src}, 16'd0);
        check("midrst_ha", {15'd0, hold_active}, 16'd0);
        rst     = 1'b0;
        msg_req = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic checked by the model on every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 399) == 0);
            alt_req   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) msg_req = ~msg_req;
            if ($urandom_range(0, 39) == 0) msg_blink = ~msg_blink;
            base_nums = rnd_nums();
            alt_nums  = rnd_nums();
            msg_nums  = rnd_nums();
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
